// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selects and the pipeline control FSM states.
package cpu_types_pkg;
    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pcu_state_t;
endpackage

// File: rtl/pipeline_control_unit_if.sv
// Handshake, hazard and register-enable bundle between the datapath and the pipeline control unit.
interface pipeline_control_unit_if;
    import cpu_types_pkg::*;

    logic     ihit, dhit;
    logic     memcuDRE, memcuDWE;
    logic     excuDRE;
    regbits_t exwsel, idrsel1, idrsel2;
    logic     memBrTaken, idJump, memHalt;

    logic     pcW;
    logic     ifW, ifRST, idW, idRST, exW, exRST, memW, memRST;

    modport master (
        output ihit, dhit, memcuDRE, memcuDWE, excuDRE, exwsel, idrsel1, idrsel2,
               memBrTaken, idJump, memHalt,
        input  pcW, ifW, ifRST, idW, idRST, exW, exRST, memW, memRST
    );

    modport slave (
        input  ihit, dhit, memcuDRE, memcuDWE, excuDRE, exwsel, idrsel1, idrsel2,
               memBrTaken, idJump, memHalt,
        output pcW, ifW, ifRST, idW, idRST, exW, exRST, memW, memRST
    );
endinterface

// File: rtl/hazard_detect.sv
// Load-use compare: a load in EX whose destination feeds either source of the ID instruction.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     excuDRE,
    input  regbits_t exwsel,
    input  regbits_t idrsel1,
    input  regbits_t idrsel2,
    output logic     loadUse
);
    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign loadUse = excuDRE && (exwsel != '0) &&
                     ((exwsel == idrsel1) || (exwsel == idrsel2));
endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline hazard/sequencing control: register enables and clears, halt drain FSM, stall/flush counters.
module pipeline_control_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_control_unit_if.slave cu,
    output logic                 halt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    pcu_state_t state, nextState;
    logic       loadUse, dStall;
    logic       stallEv, flushEv;

    hazard_detect uHazard (
        .excuDRE (cu.excuDRE),
        .exwsel  (cu.exwsel),
        .idrsel1 (cu.idrsel1),
        .idrsel2 (cu.idrsel2),
        .loadUse (loadUse)
    );

    assign dStall = (cu.memcuDRE || cu.memcuDWE) && !cu.dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            halt      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= nextState;
            halt  <= halt || (nextState == HALTED);
            if (stallEv && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flushEv && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Strict priority chain; only the winning condition drives outputs and counters.
    always_comb begin
        nextState  = state;
        stallEv    = 1'b0;
        flushEv    = 1'b0;
        cu.pcW     = cu.ihit;
        cu.ifW     = 1'b1;
        cu.idW     = 1'b1;
        cu.exW     = 1'b1;
        cu.memW    = 1'b1;
        cu.ifRST   = 1'b0;
        cu.idRST   = 1'b0;
        cu.exRST   = 1'b0;
        cu.memRST  = 1'b0;

        if (state == HALTED) begin
            cu.pcW  = 1'b0;
            cu.ifW  = 1'b0;
            cu.idW  = 1'b0;
            cu.exW  = 1'b0;
            cu.memW = 1'b0;
        end else if (dStall) begin
            cu.pcW  = 1'b0;
            cu.ifW  = 1'b0;
            cu.idW  = 1'b0;
            cu.exW  = 1'b0;
            cu.memW = 1'b0;
            stallEv = 1'b1;
        end else if (cu.memBrTaken) begin
            cu.pcW   = 1'b1;
            cu.ifRST = 1'b1;
            cu.idRST = 1'b1;
            cu.exRST = 1'b1;
            flushEv  = 1'b1;
        end else if (cu.memHalt || state == DRAIN) begin
            // Kill everything younger than the HALT and let MEM/WB retire it.
            cu.pcW   = 1'b0;
            cu.ifRST = 1'b1;
            cu.idRST = 1'b1;
            cu.exRST = 1'b1;
            if (state == DRAIN) nextState = HALTED;
            else                nextState = DRAIN;
        end else if (loadUse) begin
            cu.pcW   = 1'b0;
            cu.ifW   = 1'b0;
            cu.idRST = 1'b1;
            stallEv  = 1'b1;
        end else if (cu.idJump) begin
            cu.pcW   = 1'b1;
            cu.ifRST = 1'b1;
            flushEv  = 1'b1;
        end else if (!cu.ihit) begin
            cu.pcW   = 1'b0;
            cu.ifRST = 1'b1;
            stallEv  = 1'b1;
        end
    end
endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central hazard and sequencing controller for the five-stage pipeline. Every cycle it decides the write enable (xW) and synchronous clear (xRST) of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC write enable. Its inputs are memory handshakes, load-use hazards, control-flow redirects and halt. A small FSM drains the pipeline on halt, and saturating counters record stall and flush cycles for the testbench and debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- memcuDRE, memcuDWE  in  1 each  data read / write pending in MEM
- excuDRE  in  1  load in EX
- exwsel  in  5  destination register in EX
- idrsel1, idrsel2  in  5 each  source registers of the instruction in ID
- memBrTaken  in  1  resolved branch taken in MEM
- idJump  in  1  J/JAL/JR decoded in ID
- memHalt  in  1  HALT opcode in MEM
- pcW  out  1  PC write enable
- ifW, ifRST, idW, idRST, exW, exRST, memW, memRST  out  1 each  pipeline register enables and synchronous clears
- halt  out  1  processor halted, sticky
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- FSM states:
  - RUN: normal operation.
  - DRAIN: HALT has left MEM.
  - HALTED: processor stopped.
- Transitions:
  - RUN→DRAIN when memHalt is high and no dmem stall.
  - DRAIN→HALTED on the next memW cycle.
  - HALTED holds until nRST.
- Default in RUN: all xW=1, all xRST=0, pcW=ihit.
- Condition priority, highest first:
  1. HALTED: all xW=0, pcW=0, halt=1.
  2. dmem stall (memcuDRE|memcuDWE)&!dhit: all xW=0, pcW=0.
  3. memBrTaken: ifRST, idRST and exRST=1; pcW=1 to load the target.
  4. memHalt, or state DRAIN: pcW=0; ifRST, idRST and exRST=1; memW=1.
  5. Load-use, i.e. excuDRE & exwsel!=0 & (exwsel==idrsel1 | exwsel==idrsel2): pcW=0, ifW=0, idRST=1 to insert a bubble.
  6. idJump: ifRST=1, pcW=1.
  7. !ihit: ifRST=1 so a bubble enters IF/ID; pcW=0.
- An xRST is asserted only together with its xW=1. A clear never happens during a freeze.
- stall_cnt increments on every cycle where condition 2, 5 or 7 holds.
- flush_cnt increments on every cycle where condition 3 or 6 holds.
- Both counters saturate at all-ones; they never wrap.

## Timing
- Outputs are combinational (Mealy) from the current state and inputs. State, halt and the counters are registered on CLK rising edge.
- Reset values: state=RUN, halt=0, stall_cnt=0, flush_cnt=0.
- During reset the combinational outputs take the RUN-default values computed from the inputs.
- A load-use stall lasts exactly 1 cycle, because the load advances to MEM. It is extended by any concurrent dmem stall.
- A branch redirect costs 3 flushed slots in a single cycle.
- Halt: halt goes high 2 cycles after memHalt is first sampled with no dmem stall, and stays high.
- Simultaneous events:
  - A dmem stall masks a branch and halt until dhit.
  - memBrTaken together with idJump: branch wins; flush_cnt increments once.
  - Load-use together with !ihit: load-use wins.
- nRST asserted mid-DRAIN or mid-HALTED returns the FSM to RUN immediately and asynchronously.

## Structure
- State enum `pcu_state_t` {RUN, DRAIN, HALTED} lives in cpu_types_pkg. regbits_t is reused from that package for register selects.
- Sub-module `hazard_detect` holds the purely combinational load-use compare.
- FSM, priority mux and counters sit in the top module.

## Test plan
- Load to r5, then `add r6,r5,r1` back-to-back → one cycle of pcW=0, ifW=0, idRST=1; stall_cnt goes 0→1.
- Load with exwsel=0 followed by a consumer of r0 → no stall.
- memcuDRE=1 with dhit low for 3 cycles while memBrTaken=1 → all xW=0 for 3 cycles; the flush happens on the dhit cycle; flush_cnt goes 0→1.
- memHalt pulse → halt=1 two cycles later; pcW stays 0 thereafter; ihit has no effect.
- CNT_W=4, 20 consecutive load-use stalls → stall_cnt sticks at 15.
- nRST pulsed low while HALTED → halt=0, counters=0, pcW follows ihit.
